// File: rtl/fb_pixel_writer.sv
// Packs RGB565 pixel pairs into 32-bit framebuffer writes.
// Buffers tagged words in a show-ahead FIFO feeding a valid/ready port.
module fb_pixel_writer #(
  parameter int H_RES        = 320,
  parameter int V_RES        = 240,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_THRESH = 12,
  parameter int ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] FB_BASE = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [15:0]       pix_rgb565,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              fifo_afull,
  output logic              overflow,
  output logic              frame_done,
  output logic              busy
);

  localparam int NPIX = H_RES * V_RES;
  localparam int PW   = $clog2(NPIX);
  localparam int WW   = PW - 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(NPIX - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFTH = CW'(AFULL_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;
  logic   done_nx;

  logic [PW-1:0] pix_cnt;
  logic [15:0]   half_q;

  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [WW-1:0] mem_idx  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt;

  logic          accept, last_pix;
  logic          push_req, push_ok;
  logic          hs, load, full;
  logic [CW-1:0] occ, occ_nx;

  // Occupancy includes the word held in the output register.
  assign occ      = mem_cnt + CW'(wr_valid);
  assign full     = (occ == FULL);
  assign accept   = pix_valid && (state == RUN) && !frame_start;
  assign last_pix = accept && (pix_cnt == LAST);
  assign push_req = accept && pix_cnt[0];
  assign push_ok  = push_req && !full;
  assign hs       = wr_valid && wr_ready;
  assign load     = (mem_cnt != '0) && (!wr_valid || hs);
  assign occ_nx   = occ + CW'(push_ok) - CW'(hs);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (frame_start) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        RUN: begin
          if (last_pix) state_nx = DRAIN;
        end
        DRAIN: begin
          if (occ == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= {pix_rgb565, half_q};
      mem_idx[wr_ptr]  <= pix_cnt[PW-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      half_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      fifo_afull <= 1'b0;
      overflow   <= 1'b0;
    end else if (frame_start) begin
      pix_cnt    <= '0;
      half_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      wr_valid   <= 1'b0;
      fifo_afull <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        if (!pix_cnt[0]) half_q <= pix_rgb565;
        pix_cnt <= last_pix ? '0 : pix_cnt + PW'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_req && full) overflow <= 1'b1;
      if (load) begin
        rd_ptr   <= rd_ptr + AW'(1);
        wr_valid <= 1'b1;
        wr_addr  <= FB_BASE + (ADDR_W'(mem_idx[rd_ptr]) << 2);
        wr_data  <= mem_data[rd_ptr];
      end else if (hs) begin
        wr_valid <= 1'b0;
      end
      mem_cnt    <= mem_cnt + CW'(push_ok) - CW'(load);
      fifo_afull <= (occ_nx >= AFTH);
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: default build plus a 4x2 build.
// Table-driven basic packing, hand sequences for stall/overflow/reset.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic [15:0] pix_rgb565 = '0;

  logic [31:0] wr_addr, wr_data;
  logic        wr_valid, fifo_afull, overflow, frame_done, busy;
  logic [31:0] s_wr_addr, s_wr_data;
  logic        s_wr_valid, s_fifo_afull, s_overflow, s_frame_done, s_busy;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [31:0] BASE = 32'h1000_0000;

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_rgb565(pix_rgb565), .pix_valid(pix_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .fifo_afull(fifo_afull),
    .overflow(overflow), .frame_done(frame_done), .busy(busy)
  );

  fb_pixel_writer #(.H_RES(4), .V_RES(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_rgb565(pix_rgb565), .pix_valid(pix_valid),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_valid(s_wr_valid),
    .wr_ready(wr_ready), .fifo_afull(s_fifo_afull),
    .overflow(s_overflow), .frame_done(s_frame_done), .busy(s_busy)
  );

  typedef struct {
    logic        fs;
    logic        v;
    logic [15:0] pix;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_afull;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic v,
                       input logic [15:0] p, input logic r);
    frame_start = fs;
    pix_valid   = v;
    pix_rgb565  = p;
    wr_ready    = r;
  endtask

  function automatic vec_t mk(input logic fs, input logic v,
                              input logic [15:0] p, input logic r,
                              input logic ev, input logic [31:0] ea,
                              input logic [31:0] ed);
    vec_t t;
    t.fs = fs; t.v = v; t.pix = p; t.rdy = r;
    t.e_valid = ev; t.e_addr = ea; t.e_data = ed;
    t.e_afull = 1'b0; t.e_ovf = 1'b0; t.e_busy = 1'b1;
    return t;
  endfunction

  initial begin
    logic [31:0] exp_w [4];
    int nw;
    int n_done;

    tbl[0] = mk(1, 0, 16'h0000, 1, 0, '0, '0);
    tbl[1] = mk(0, 1, 16'h1111, 1, 0, '0, '0);
    tbl[2] = mk(0, 1, 16'h2222, 1, 0, '0, '0);
    tbl[3] = mk(0, 1, 16'h3333, 1, 1, BASE, 32'h2222_1111);
    tbl[4] = mk(0, 1, 16'h4444, 1, 0, '0, '0);
    tbl[5] = mk(0, 0, 16'h0000, 1, 1, BASE + 32'h4, 32'h4444_3333);
    tbl[6] = mk(0, 0, 16'h0000, 1, 0, '0, '0);

    // Reset state
    step(); step();
    chk("reset_outs",
        {wr_valid, wr_addr, wr_data, fifo_afull, overflow, frame_done, busy},
        '0);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", {busy, wr_valid}, 2'b00);

    // Basic packing table
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].fs, tbl[i].v, tbl[i].pix, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_flags", i),
          {wr_valid, fifo_afull, overflow, busy},
          {tbl[i].e_valid, tbl[i].e_afull, tbl[i].e_ovf, tbl[i].e_busy});
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].e_data);
      end
    end

    // Stall, almost-full and overflow
    drive(1, 0, 0, 0);
    step();
    for (int i = 0; i < 36; i++) begin
      drive(0, 1, 16'hA000 + 16'(i), 0);
      step();
      if (i == 22) chk("afull_11w", fifo_afull, 1'b0);
      if (i == 23) chk("afull_12w", fifo_afull, 1'b1);
      if (i == 20) chk("stall_w0", {wr_valid, wr_addr, wr_data},
                       {1'b1, BASE, 32'hA001_A000});
      if (i == 31) chk("ovf_16w", overflow, 1'b0);
      if (i == 33) chk("ovf_drop", overflow, 1'b1);
    end
    drive(0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), {wr_valid, wr_addr, wr_data},
          {1'b1, BASE + 32'(4 * k),
           16'hA000 + 16'(2 * k + 1), 16'hA000 + 16'(2 * k)});
      if (k == 5) begin
        wr_ready = 1'b0;
        step();
        chk("drain_hold", {wr_valid, wr_addr, wr_data},
            {1'b1, BASE + 32'h14, 32'hA00B_A00A});
        wr_ready = 1'b1;
      end
      step();
    end
    chk("drain_empty", wr_valid, 1'b0);
    drive(0, 1, 16'hA024, 1);
    step();
    pix_rgb565 = 16'hA025;
    step();
    pix_valid = 1'b0;
    step();
    chk("after_drop_addr", {wr_valid, wr_addr, wr_data, overflow},
        {1'b1, BASE + 32'h48, 32'hA025_A024, 1'b1});
    step();

    // Mid-frame restart with queued words and a pending half
    wr_ready = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pix_rgb565 = 16'hB000 + 16'(i);
      step();
    end
    pix_valid = 1'b0;
    chk("mid_pre", {wr_valid, wr_addr, overflow},
        {1'b1, BASE + 32'h4C, 1'b1});
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("mid_flush", {wr_valid, overflow, busy}, 3'b001);
    drive(0, 1, 16'h5A5A, 1);
    step();
    pix_rgb565 = 16'h6B6B;
    step();
    pix_valid = 1'b0;
    step();
    chk("mid_word0", {wr_valid, wr_addr, wr_data, fifo_afull},
        {1'b1, BASE, 32'h6B6B_5A5A, 1'b0});
    step();

    // Coincident frame_start and pixel
    drive(1, 1, 16'hDEAD, 1);
    step();
    drive(0, 1, 16'h0A0A, 1);
    step();
    pix_rgb565 = 16'h0B0B;
    step();
    pix_valid = 1'b0;
    step();
    chk("coinc_word0", {wr_valid, wr_addr, wr_data},
        {1'b1, BASE, 32'h0B0B_0A0A});
    step();

    // Asynchronous reset mid-traffic
    drive(1, 0, 0, 0);
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_rgb565 = 16'hC100 + 16'(i);
      step();
    end
    pix_valid = 1'b0;
    chk("rst_pre", {wr_valid, busy}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async",
        {wr_valid, wr_addr, wr_data, fifo_afull, overflow, frame_done, busy},
        '0);
    step();
    rst_n = 1'b1;
    pix_valid = 1'b1;
    wr_ready = 1'b1;
    step(); step(); step();
    pix_valid = 1'b0;
    chk("rst_after", {wr_valid, busy, s_wr_valid, s_busy}, 4'b0000);

    // Small 4x2 frame
    for (int k = 0; k < 4; k++)
      exp_w[k] = {16'hC000 + 16'(2 * k + 1), 16'hC000 + 16'(2 * k)};
    nw = 0;
    n_done = 0;
    drive(1, 0, 0, 1);
    step();
    for (int c = 0; c < 20; c++) begin
      drive(0, c < 8, 16'hC000 + 16'(c), 1);
      step();
      if (s_wr_valid) begin
        if (nw < 4) begin
          chk($sformatf("small_w%0d", nw), {s_wr_addr, s_wr_data},
              {BASE + 32'(4 * nw), exp_w[nw]});
        end else begin
          chk("small_extra_word", 1'b1, 1'b0);
        end
        nw++;
      end
      if (s_frame_done) begin
        n_done++;
        chk("small_done_after_last", {32'(nw), s_wr_valid, s_busy},
            {32'd4, 1'b0, 1'b0});
      end
    end
    chk("small_nwords", nw, 4);
    chk("small_done_pulses", n_done, 1);
    drive(0, 1, 16'hEEEE, 1);
    step();
    pix_valid = 1'b0;
    step(); step(); step();
    chk("small_pix9_ignored",
        {s_wr_valid, s_busy, s_frame_done, s_overflow}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Downstream of the iteration-to-RGB565 colour stage. Consumes its registered rgb565/valid pixel stream in raster order.
- Packs two pixels per 32-bit word, tags each word with its framebuffer address, buffers words in a small FIFO and issues them on a valid/ready write port to the memory writer.
- The colour stage cannot be stalled. This block exports an almost-full flag for the upstream pixel scheduler and flags dropped data.

Parameters:
- H_RES, 320, pixels per line (must be even)
- V_RES, 240, lines per frame
- FIFO_DEPTH, 16, packed words buffered (power of two)
- AFULL_THRESH, 12, FIFO occupancy at which fifo_afull asserts
- ADDR_W, 32, write address width
- FB_BASE, 32'h1000_0000, byte address of pixel (0,0)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; arms a new frame
- pix_rgb565  in  16  pixel colour from colour stage
- pix_valid  in  1  pixel qualifier, no backpressure
- wr_addr  out  ADDR_W  byte address of wr_data
- wr_data  out  32  packed pixels {second, first}
- wr_valid  out  1  write request
- wr_ready  in  1  write accepted when wr_valid&&wr_ready
- fifo_afull  out  1  occupancy >= AFULL_THRESH (registered)
- overflow  out  1  sticky: a word was dropped on a full FIFO
- frame_done  out  1  one-cycle pulse, frame fully written
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, pixel/word counters 0, half-pixel latch empty. All outputs 0; wr_addr=0.
- States:
  - IDLE -> RUN on frame_start.
  - RUN -> DRAIN on the cycle the last pixel (index H_RES*V_RES-1) is accepted.
  - DRAIN -> IDLE when the FIFO is empty and no handshake is pending; frame_done pulses for 1 cycle on that transition.
- frame_start in any state: discard FIFO contents, clear half latch, reset word index to 0, clear overflow, enter RUN.
  - frame_start has priority over a coincident pix_valid; that pixel is discarded.
  - wr_valid is 0 the cycle after frame_start.
- Packing in RUN:
  - Even pixel is latched into wr_data[15:0].
  - Odd pixel completes the word {odd, latched_even} and pushes {word_index, data} on the same edge.
  - word_index = pixel_index>>1, range 0..H_RES*V_RES/2-1, 16 bits for defaults.
- Pixels with pix_valid in IDLE or DRAIN are ignored and have no flag effect.
- Push when FIFO full: the word is dropped, overflow<=1, and word_index still advances, so later words keep correct addresses.
  - Push-when-full is dropped even if a pop occurs the same cycle.
- FIFO is show-ahead with registered outputs:
  - Word pushed at edge N appears with wr_valid=1 after edge N+1 at earliest.
  - wr_addr = FB_BASE + 4*word_index, computed in ADDR_W bits with wrap.
  - wr_addr/wr_data/wr_valid hold stable while wr_valid&&!wr_ready.
  - Pop on handshake; the next entry is presented the following cycle. One word per cycle sustained when wr_ready=1.
- Simultaneous push and pop when not full: occupancy unchanged.
- fifo_afull is registered from next-occupancy (lags by zero cycles relative to count).
- overflow is cleared only by frame_start or reset.

Test Plan:
1. Assert rst_n=0 mid-traffic, with wr_valid=1 and the FIFO holding 5 words -> all outputs 0 immediately (asynchronously). After release, busy=0 and no wr_valid until frame_start.
2. frame_start, then pixels 16'h1111, 16'h2222, 16'h3333, 16'h4444 with wr_ready=1 -> wr_data 32'h2222_1111 @ 32'h1000_0000, then 32'h4444_3333 @ 32'h1000_0004. First wr_valid appears 1 cycle after the 2nd pixel edge.
3. Hold wr_ready=0 and stream 36 pixels:
   - fifo_afull=1 once 12 words are queued (24th pixel).
   - FIFO is full at the 32nd pixel; words 16 and 17 are dropped and overflow=1.
   - Release wr_ready -> 16 words at addr offsets 0x00..0x3C, in order, stable while stalled.
   - The next pair lands at offset 0x48.
4. H_RES=4, V_RES=2 build: frame_start plus 8 pixels -> 4 words at offsets 0,4,8,C. frame_done is a single pulse after the last handshake, then busy=0. A 9th pixel is ignored.
5. Mid-frame frame_start with 3 words queued and a half latch pending -> next cycle wr_valid=0 and overflow=0. The next pixel pair is written at 32'h1000_0000.
6. Coincident frame_start and pix_valid -> that pixel is discarded. The following two pixels form word 0.
